// File: rtl/mips_core_pkg.sv
// Shared types and sizing for the out-of-order core's issue stage.
// Everything issue-side imports this so tag and slot widths stay in one place.
package mips_core_pkg;

    localparam int NUM_ENTRIES   = 32;
    localparam int SLOT_W        = 5;
    localparam int PREG_W        = 6;
    localparam int AL_W          = 5;
    localparam int NUM_PHYS_REGS = 64;

    typedef logic [PREG_W-1:0] PhysReg;
    typedef logic [SLOT_W-1:0] IssueSlot;
    typedef logic [AL_W-1:0]   AlIndex;
    typedef logic [SLOT_W:0]   OccCount;

    typedef struct packed {
        logic   rdy_rs;
        logic   rdy_rt;
        PhysReg rs_tag;
        PhysReg rt_tag;
        AlIndex al_index;
    } sched_entry_t;

    // A source is ready if unused, tag 0, already written, or written back this very cycle.
    function automatic logic src_ready(input logic uses, input PhysReg tag, input logic preg_rdy,
                                       input logic wb_valid, input PhysReg wb_tag);
        return !uses || (tag == '0) || preg_rdy || (wb_valid && (wb_tag == tag));
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Allocation, writeback, issue and flush signals between rename, the FUs and the scheduler.
// master = the pipeline around the scheduler, slave = the scheduler itself.
interface issue_scheduler_if;
    import mips_core_pkg::*;

    logic     alloc_valid;
    logic     alloc_ready;
    logic     alloc_uses_rs;
    PhysReg   alloc_rs_tag;
    logic     alloc_uses_rt;
    PhysReg   alloc_rt_tag;
    logic     alloc_uses_rw;
    PhysReg   alloc_rw_tag;
    AlIndex   alloc_al_index;
    IssueSlot alloc_slot;
    logic     wb_valid;
    PhysReg   wb_tag;
    logic     issue_valid;
    logic     issue_ready;
    IssueSlot issue_slot;
    AlIndex   issue_al_index;
    logic     flush;
    OccCount  occupancy;

    modport master (
        output alloc_valid, alloc_uses_rs, alloc_rs_tag, alloc_uses_rt, alloc_rt_tag,
               alloc_uses_rw, alloc_rw_tag, alloc_al_index, wb_valid, wb_tag,
               issue_ready, flush,
        input  alloc_ready, alloc_slot, issue_valid, issue_slot, issue_al_index, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_uses_rs, alloc_rs_tag, alloc_uses_rt, alloc_rt_tag,
               alloc_uses_rw, alloc_rw_tag, alloc_al_index, wb_valid, wb_tag,
               issue_ready, flush,
        output alloc_ready, alloc_slot, issue_valid, issue_slot, issue_al_index, occupancy
    );

endinterface

// File: rtl/age_select.sv
// Oldest-first select: age[i][j] set means slot j was allocated before slot i.
module age_select
    import mips_core_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0]                  eligible,
    input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age,
    output logic [NUM_ENTRIES-1:0]                  grant,
    output IssueSlot                                grant_idx
);

    // The age matrix is a total order over valid slots, so at most one grant bit is set.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            grant[i] = eligible[i] & ~|(age[i] & eligible);
        end
    end

    priority_encoder #(.WIDTH(NUM_ENTRIES)) u_grant_enc (
        .req (grant),
        .idx (grant_idx)
    );

endmodule

// File: rtl/priority_encoder.sv
// Binary index of the lowest set request bit; returns 0 when nothing is requested.
module priority_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        // NOTE: default first so every path assigns idx and no latch is inferred.
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Wakeup/select bookkeeping for the issue queue: physical-register readiness, per-slot
// source readiness and age order. The payload RAM lives outside and follows alloc_slot/issue_slot.
module issue_scheduler
    import mips_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    issue_scheduler_if.slave sched
);

    logic [NUM_ENTRIES-1:0]                  valid_q;
    sched_entry_t                            entry_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q;
    logic [NUM_PHYS_REGS-1:0]                preg_ready_q;
    OccCount                                 occupancy_q;
    OccCount                                 occupancy_d;

    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] grant;
    logic [NUM_ENTRIES-1:0] issue_onehot;
    IssueSlot               sel_slot;
    IssueSlot               free_slot;
    logic                   any_eligible;
    logic                   alloc_fire;
    logic                   issue_fire;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            eligible[i] = valid_q[i] & entry_q[i].rdy_rs & entry_q[i].rdy_rt;
        end
    end

    age_select u_age_select (
        .eligible  (eligible),
        .age       (age_q),
        .grant     (grant),
        .grant_idx (sel_slot)
    );

    priority_encoder #(.WIDTH(NUM_ENTRIES)) u_free_enc (
        .req (~valid_q),
        .idx (free_slot)
    );

    // No credit for a same-cycle issue: a full queue stays full for this cycle.
    assign sched.alloc_ready    = (occupancy_q < OccCount'(NUM_ENTRIES)) & ~sched.flush;
    assign sched.alloc_slot     = free_slot;
    assign any_eligible         = |eligible;
    assign sched.issue_valid    = any_eligible & ~sched.flush;
    assign sched.issue_slot     = sel_slot;
    assign sched.issue_al_index = any_eligible ? entry_q[sel_slot].al_index : '0;
    assign sched.occupancy      = occupancy_q;

    assign alloc_fire   = sched.alloc_valid & sched.alloc_ready;
    assign issue_fire   = sched.issue_valid & sched.issue_ready;
    assign issue_onehot = issue_fire ? grant : '0;

    always_comb begin
        occupancy_d = occupancy_q;
        if (alloc_fire && !issue_fire)      occupancy_d = occupancy_q + OccCount'(1);
        else if (issue_fire && !alloc_fire) occupancy_d = occupancy_q - OccCount'(1);
    end

    // NOTE: these arrays are flops rather than a RAM, so they take the async reset with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            age_q        <= '0;
            preg_ready_q <= '1;
            occupancy_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
        end else if (sched.flush) begin
            valid_q      <= '0;
            age_q        <= '0;
            preg_ready_q <= '1;
            occupancy_q  <= '0;
        end else begin
            occupancy_q <= occupancy_d;

            // NOTE: non-blocking only; the later destination clear below overrides the wakeup set.
            if (sched.wb_valid) begin
                preg_ready_q[sched.wb_tag] <= 1'b1;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (valid_q[i] && entry_q[i].rs_tag == sched.wb_tag) entry_q[i].rdy_rs <= 1'b1;
                    if (valid_q[i] && entry_q[i].rt_tag == sched.wb_tag) entry_q[i].rdy_rt <= 1'b1;
                end
            end

            if (issue_fire) valid_q[sel_slot] <= 1'b0;

            if (alloc_fire) begin
                valid_q[free_slot] <= 1'b1;
                entry_q[free_slot] <= '{
                    rdy_rs:   src_ready(sched.alloc_uses_rs, sched.alloc_rs_tag,
                                        preg_ready_q[sched.alloc_rs_tag], sched.wb_valid, sched.wb_tag),
                    rdy_rt:   src_ready(sched.alloc_uses_rt, sched.alloc_rt_tag,
                                        preg_ready_q[sched.alloc_rt_tag], sched.wb_valid, sched.wb_tag),
                    rs_tag:   sched.alloc_rs_tag,
                    rt_tag:   sched.alloc_rt_tag,
                    al_index: sched.alloc_al_index
                };
                // New slot is younger than every survivor; nobody may still count it as older.
                for (int r = 0; r < NUM_ENTRIES; r++) age_q[r][free_slot] <= 1'b0;
                age_q[free_slot] <= valid_q & ~issue_onehot;
                if (sched.alloc_uses_rw && sched.alloc_rw_tag != '0) begin
                    preg_ready_q[sched.alloc_rw_tag] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: ordering, wakeup bypass, full queue, stall, flush, reset.
module tb_issue_scheduler;
    import mips_core_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vectors;
    int   n_miscompares;

    issue_scheduler_if sif ();

    issue_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        sif.alloc_valid    = 1'b0;
        sif.alloc_uses_rs  = 1'b0;
        sif.alloc_rs_tag   = '0;
        sif.alloc_uses_rt  = 1'b0;
        sif.alloc_rt_tag   = '0;
        sif.alloc_uses_rw  = 1'b0;
        sif.alloc_rw_tag   = '0;
        sif.alloc_al_index = '0;
        sif.wb_valid       = 1'b0;
        sif.wb_tag         = '0;
        sif.flush          = 1'b0;
    endtask

    task automatic alloc(input logic urs, input PhysReg rs, input logic urw, input PhysReg rw,
                         input AlIndex al);
        sif.alloc_valid    = 1'b1;
        sif.alloc_uses_rs  = urs;
        sif.alloc_rs_tag   = rs;
        sif.alloc_uses_rt  = 1'b0;
        sif.alloc_rt_tag   = '0;
        sif.alloc_uses_rw  = urw;
        sif.alloc_rw_tag   = rw;
        sif.alloc_al_index = al;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        idle();
        sif.issue_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_occupancy", sif.occupancy, 0);
        check("rst_alloc_ready", sif.alloc_ready, 1);
        check("rst_issue_valid", sif.issue_valid, 0);
        check("rst_alloc_slot", sif.alloc_slot, 0);
        check("rst_issue_slot", sif.issue_slot, 0);
        check("rst_issue_al", sif.issue_al_index, 0);
        tick();
        rst_n = 1'b1;

        // Three independent instructions, issued in allocation order.
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd1);
        sample();
        check("t1_slot0", sif.alloc_slot, 0);
        check("t1_no_issue_yet", sif.issue_valid, 0);
        tick();
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd2);
        sample();
        check("t1_slot1", sif.alloc_slot, 1);
        check("t1_issue_valid_c2", sif.issue_valid, 1);
        tick();
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd3);
        sample();
        check("t1_slot2", sif.alloc_slot, 2);
        tick();
        idle();
        sif.issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t1_issue_slot", sif.issue_slot, k);
            check("t1_issue_al", sif.issue_al_index, k + 1);
            tick();
        end
        sample();
        check("t1_drained_valid", sif.issue_valid, 0);
        check("t1_drained_occ", sif.occupancy, 0);
        tick();

        // A writes p9, B reads p9, C independent: order A, C, then B after the writeback.
        sif.issue_ready = 1'b0;
        alloc(1'b0, 6'd0, 1'b1, 6'd9, 5'd4);
        tick();
        alloc(1'b1, 6'd9, 1'b0, 6'd0, 5'd5);
        tick();
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd6);
        tick();
        idle();
        sif.issue_ready = 1'b1;
        sample();
        check("t2_first_A", sif.issue_slot, 0);
        tick();
        sample();
        check("t2_second_C", sif.issue_slot, 2);
        check("t2_second_C_al", sif.issue_al_index, 6);
        tick();
        sample();
        check("t2_B_blocked", sif.issue_valid, 0);
        tick();
        sif.wb_valid = 1'b1;
        sif.wb_tag   = 6'd9;
        sample();
        check("t2_B_blocked_wb_cycle", sif.issue_valid, 0);
        tick();
        idle();
        sample();
        check("t2_B_woken", sif.issue_valid, 1);
        check("t2_B_slot", sif.issue_slot, 1);
        check("t2_B_al", sif.issue_al_index, 5);
        tick();
        sample();
        check("t2_occ", sif.occupancy, 0);
        tick();

        // Same-cycle writeback of p12 while allocating a reader of p12.
        alloc(1'b0, 6'd0, 1'b1, 6'd12, 5'd8);
        tick();
        alloc(1'b1, 6'd12, 1'b0, 6'd0, 5'd9);
        sif.wb_valid = 1'b1;
        sif.wb_tag   = 6'd12;
        sample();
        check("t3_D_issue", sif.issue_slot, 0);
        check("t3_E_alloc_slot", sif.alloc_slot, 1);
        tick();
        idle();
        sample();
        check("t3_E_eligible", sif.issue_valid, 1);
        check("t3_E_slot", sif.issue_slot, 1);
        check("t3_E_al", sif.issue_al_index, 9);
        tick();
        sample();
        check("t3_occ", sif.occupancy, 0);
        tick();

        // Fill all slots, free one, reuse it, then drain checking age order and a stall on slot 5.
        sif.issue_ready = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            alloc(1'b0, 6'd0, 1'b0, 6'd0, AlIndex'(i));
            sample();
            check("t4_fill_slot", sif.alloc_slot, i);
            tick();
        end
        idle();
        sif.alloc_valid = 1'b1;
        sif.issue_ready = 1'b1;
        sample();
        check("t4_full_ready", sif.alloc_ready, 0);
        check("t4_full_occ", sif.occupancy, 32);
        check("t4_oldest", sif.issue_slot, 0);
        tick();
        sif.issue_ready = 1'b0;
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd7);
        sample();
        check("t4_ready_again", sif.alloc_ready, 1);
        check("t4_reuse_slot", sif.alloc_slot, 0);
        check("t4_occ31", sif.occupancy, 31);
        tick();
        idle();
        sif.issue_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            sample();
            check("t4_order", sif.issue_slot, k);
            tick();
        end
        sif.issue_ready = 1'b0;
        repeat (4) begin
            sample();
            check("t5_stall_valid", sif.issue_valid, 1);
            check("t5_stall_slot", sif.issue_slot, 5);
            tick();
        end
        sif.issue_ready = 1'b1;
        for (int k = 5; k < NUM_ENTRIES; k++) begin
            sample();
            check("t4_order", sif.issue_slot, k);
            if (k == 5) check("t5_slot5_al", sif.issue_al_index, 5);
            tick();
        end
        sample();
        check("t4_reused_youngest", sif.issue_slot, 0);
        check("t4_reused_al", sif.issue_al_index, 7);
        tick();
        sample();
        check("t4_drained", sif.issue_valid, 0);
        check("t4_drained_occ", sif.occupancy, 0);
        tick();

        // Flush with 10 entries, concurrent alloc and wakeup dropped; p20 must come back ready.
        sif.issue_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            alloc(1'b0, 6'd0, (i == 0), 6'd20, AlIndex'(i));
            tick();
        end
        idle();
        sample();
        check("t6_occ10", sif.occupancy, 10);
        tick();
        sif.flush       = 1'b1;
        sif.issue_ready = 1'b1;
        alloc(1'b0, 6'd0, 1'b0, 6'd0, 5'd1);
        sif.wb_valid = 1'b1;
        sif.wb_tag   = 6'd3;
        sample();
        check("t6_flush_alloc_ready", sif.alloc_ready, 0);
        check("t6_flush_issue_valid", sif.issue_valid, 0);
        tick();
        idle();
        sif.issue_ready = 1'b0;
        sample();
        check("t6_post_occ", sif.occupancy, 0);
        check("t6_post_alloc_slot", sif.alloc_slot, 0);
        check("t6_post_issue_valid", sif.issue_valid, 0);
        alloc(1'b1, 6'd20, 1'b0, 6'd0, 5'd12);
        tick();
        idle();
        sample();
        check("t6_preg20_ready", sif.issue_valid, 1);
        check("t6_F_slot", sif.issue_slot, 0);
        check("t6_F_al", sif.issue_al_index, 12);
        check("t6_occ1", sif.occupancy, 1);

        // Asynchronous reset mid-cycle clears state without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_occ", sif.occupancy, 0);
        check("rst_async_issue_valid", sif.issue_valid, 0);
        check("rst_async_alloc_ready", sif.alloc_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
